// File: rtl/stack_ptr_pkg.sv
// stack_ptr_pkg: shared word width, pointer defaults and bus/word bit-order helpers
package stack_ptr_pkg;
    localparam int WORD_W = 16;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [0:WORD_W-1] bus_t;
    localparam word_t EMPTY_SP_DEF = 16'h0000;
    localparam word_t LIMIT_SP_DEF = 16'hF000;
    typedef enum logic [2:0] {OP_IDLE, OP_LOAD, OP_BOTH, OP_PUSH, OP_POP} op_t;
    // External buses are [0:15] with bit 0 as LSB; copy index-for-index into numeric words
    function automatic word_t bus2word(input bus_t b);
        word_t w;
        for (int i = 0; i < WORD_W; i++) w[i] = b[i];
        return w;
    endfunction
    function automatic bus_t word2bus(input word_t w);
        bus_t b;
        for (int i = 0; i < WORD_W; i++) b[i] = w[i];
        return b;
    endfunction
endpackage

// File: rtl/sp_addsub16.sv
// sp_addsub16: modulo-2^16 increment or decrement by one
module sp_addsub16
    import stack_ptr_pkg::*;
(
    input  word_t a,
    input  logic  dec,
    output word_t y
);
    assign y = dec ? a - word_t'(1) : a + word_t'(1);
endmodule

// File: rtl/stack_ptr.sv
// stack_ptr: downward-growing stack pointer with depth tracking and sticky error flags
module stack_ptr
    import stack_ptr_pkg::*;
#(
    parameter word_t EMPTY_SP = EMPTY_SP_DEF,
    parameter word_t LIMIT_SP = LIMIT_SP_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_load,
    input  logic [0:WORD_W-1] i_load_val,
    input  logic              i_clr_err,
    output logic [0:WORD_W-1] o_sp,
    output logic [0:WORD_W-1] o_addr,
    output logic              o_valid,
    output logic              o_we,
    output logic [0:WORD_W-1] o_depth,
    output logic              o_overflow,
    output logic              o_underflow
);
    word_t sp, addr, depth, ld, sp_step, depth_step;
    op_t   op;
    logic  push_ok, pop_ok, both_ok, ovf_ev, unf_ev;
    always_comb begin
        ld      = bus2word(i_load_val);
        op      = i_load ? OP_LOAD : (i_push && i_pop) ? OP_BOTH :
                  i_push ? OP_PUSH : i_pop ? OP_POP : OP_IDLE;
        push_ok = op == OP_PUSH && sp != LIMIT_SP;
        pop_ok  = op == OP_POP && sp != EMPTY_SP;
        both_ok = op == OP_BOTH && depth != '0;
        ovf_ev  = op == OP_PUSH && sp == LIMIT_SP;
        unf_ev  = (op == OP_POP && sp == EMPTY_SP) || (op == OP_BOTH && depth == '0);
    end
    sp_addsub16 u_sp_step (.a(sp), .dec(op == OP_PUSH), .y(sp_step));
    sp_addsub16 u_depth_step (.a(depth), .dec(op == OP_POP), .y(depth_step));
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sp          <= EMPTY_SP;
            addr        <= EMPTY_SP;
            depth       <= '0;
            o_valid     <= 1'b0;
            o_we        <= 1'b0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            o_valid     <= push_ok || pop_ok || both_ok;
            o_we        <= push_ok || both_ok;
            o_overflow  <= (o_overflow && !i_clr_err) || ovf_ev;
            o_underflow <= (o_underflow && !i_clr_err) || unf_ev;
            if (op == OP_LOAD) begin
                sp    <= ld;
                depth <= EMPTY_SP - ld;
            end else if (push_ok || pop_ok) begin
                sp    <= sp_step;
                depth <= depth_step;
            end
            // Push pre-decrements; pop and replace-top address the current top
            if (push_ok) addr <= sp_step;
            else if (pop_ok || both_ok) addr <= sp;
        end
    end
    assign o_sp    = word2bus(sp);
    assign o_addr  = word2bus(addr);
    assign o_depth = word2bus(depth);
endmodule

// File: tb/tb_stack_ptr.sv
// tb_stack_ptr: directed vectors with a per-cycle expectation queue checked by a monitor
module tb_stack_ptr;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        push = 0, pop = 0, load = 0, clr = 0;
    logic [0:15] load_val = '0;
    logic [0:15] sp_b, addr_b, depth_b;
    logic        valid, we, ovf, unf;
    int          errors = 0, checks = 0;

    typedef struct packed {
        logic        v, we;
        logic [15:0] a, s, d;
        logic        ov, un;
    } exp_t;
    exp_t q[$];

    stack_ptr dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_push(push), .i_pop(pop), .i_load(load),
        .i_load_val(load_val), .i_clr_err(clr), .o_sp(sp_b), .o_addr(addr_b),
        .o_valid(valid), .o_we(we), .o_depth(depth_b), .o_overflow(ovf), .o_underflow(unf)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] num(input logic [0:15] b);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = b[i];
        return r;
    endfunction

    function automatic logic [0:15] bus(input logic [15:0] w);
        logic [0:15] r;
        for (int i = 0; i < 16; i++) r[i] = w[i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".valid"}, 16'(valid), 16'(e.v));
        chk({tag, ".we"}, 16'(we), 16'(e.we));
        chk({tag, ".addr"}, num(addr_b), e.a);
        chk({tag, ".sp"}, num(sp_b), e.s);
        chk({tag, ".depth"}, num(depth_b), e.d);
        chk({tag, ".ovf"}, 16'(ovf), 16'(e.ov));
        chk({tag, ".unf"}, 16'(unf), 16'(e.un));
    endtask

    // Monitor: one expectation per stimulated cycle; otherwise no transfer may appear
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) chk_all("cycle", q.pop_front());
            else chk("stray_valid", 16'(valid), 16'h0);
        end
    end

    task automatic step(input logic pu, po, ld, input logic [15:0] lv, input logic cl,
                        input logic v, w, input logic [15:0] a, s, d, input logic ov, un);
        @(negedge clk);
        push = pu; pop = po; load = ld; load_val = bus(lv); clr = cl;
        q.push_back('{v: v, we: w, a: a, s: s, d: d, ov: ov, un: un});
    endtask

    task automatic idle_inputs();
        push = 0; pop = 0; load = 0; clr = 0; load_val = '0;
    endtask

    initial begin
        #12;
        chk_all("reset", '{v: 0, we: 0, a: 16'h0000, s: 16'h0000, d: 16'h0000, ov: 0, un: 0});
        @(negedge clk);
        rst_n = 1'b1;
        //     pu po ld val      clr  v we addr     sp       depth   ov un
        step(1, 0, 0, 16'h0000, 0,   1, 1, 16'hFFFF, 16'hFFFF, 16'd1, 0, 0);
        step(1, 0, 0, 16'h0000, 0,   1, 1, 16'hFFFE, 16'hFFFE, 16'd2, 0, 0);
        step(1, 0, 0, 16'h0000, 0,   1, 1, 16'hFFFD, 16'hFFFD, 16'd3, 0, 0);
        step(0, 1, 0, 16'h0000, 0,   1, 0, 16'hFFFD, 16'hFFFE, 16'd2, 0, 0);
        step(0, 1, 0, 16'h0000, 0,   1, 0, 16'hFFFE, 16'hFFFF, 16'd1, 0, 0);
        step(0, 1, 0, 16'h0000, 0,   1, 0, 16'hFFFF, 16'h0000, 16'd0, 0, 0);
        step(0, 1, 0, 16'h0000, 0,   0, 0, 16'hFFFF, 16'h0000, 16'd0, 0, 1);
        step(0, 0, 0, 16'h0000, 1,   0, 0, 16'hFFFF, 16'h0000, 16'd0, 0, 0);
        step(1, 0, 0, 16'h0000, 0,   1, 1, 16'hFFFF, 16'hFFFF, 16'd1, 0, 0);
        step(1, 0, 0, 16'h0000, 0,   1, 1, 16'hFFFE, 16'hFFFE, 16'd2, 0, 0);
        step(1, 1, 0, 16'h0000, 0,   1, 1, 16'hFFFE, 16'hFFFE, 16'd2, 0, 0);
        step(0, 0, 0, 16'h0000, 0,   0, 0, 16'hFFFE, 16'hFFFE, 16'd2, 0, 0);
        step(0, 1, 0, 16'h0000, 0,   1, 0, 16'hFFFE, 16'hFFFF, 16'd1, 0, 0);
        step(0, 1, 0, 16'h0000, 0,   1, 0, 16'hFFFF, 16'h0000, 16'd0, 0, 0);
        step(1, 1, 0, 16'h0000, 0,   0, 0, 16'hFFFF, 16'h0000, 16'd0, 0, 1);
        step(0, 1, 0, 16'h0000, 1,   0, 0, 16'hFFFF, 16'h0000, 16'd0, 0, 1);
        step(0, 0, 0, 16'h0000, 1,   0, 0, 16'hFFFF, 16'h0000, 16'd0, 0, 0);
        step(0, 0, 1, 16'hF001, 0,   0, 0, 16'hFFFF, 16'hF001, 16'h0FFF, 0, 0);
        step(1, 0, 0, 16'h0000, 0,   1, 1, 16'hF000, 16'hF000, 16'h1000, 0, 0);
        step(1, 0, 0, 16'h0000, 0,   0, 0, 16'hF000, 16'hF000, 16'h1000, 1, 0);
        step(0, 0, 0, 16'h0000, 1,   0, 0, 16'hF000, 16'hF000, 16'h1000, 0, 0);
        step(1, 1, 1, 16'h0005, 0,   0, 0, 16'hF000, 16'h0005, 16'hFFFB, 0, 0);
        // Reset pulse between edges while a push is pending
        @(negedge clk);
        push = 1;
        #2 rst_n = 1'b0;
        #1 chk_all("async_rst", '{v: 0, we: 0, a: 16'h0000, s: 16'h0000, d: 16'h0000, ov: 0, un: 0});
        @(posedge clk);
        #1 chk_all("rst_hold", '{v: 0, we: 0, a: 16'h0000, s: 16'h0000, d: 16'h0000, ov: 0, un: 0});
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        step(0, 0, 0, 16'h0000, 0,   0, 0, 16'h0000, 16'h0000, 16'd0, 0, 0);
        step(1, 0, 0, 16'h0000, 0,   1, 1, 16'hFFFF, 16'hFFFF, 16'd1, 0, 0);
        @(negedge clk);
        idle_inputs();
        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", 16'(q.size()), 16'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stack_ptr.md
STACK_PTR -- requirements
Module: stack_ptr

Interface
REQ-001 Parameter EMPTY_SP, default 16'h0000, SHALL be the stack-pointer value for an empty stack; the stack grows downward.
REQ-002 Parameter LIMIT_SP, default 16'hF000, SHALL be the stack-pointer value for a full stack.
REQ-003 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 i_rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 i_push  input  1  SHALL request a push this cycle.
REQ-006 i_pop  input  1  SHALL request a pop this cycle.
REQ-007 i_load  input  1  SHALL request loading i_load_val into the pointer.
REQ-008 i_load_val  input  16  SHALL be the load value; all 16-bit buses are [0:15], index 0 = LSB.
REQ-009 i_clr_err  input  1  SHALL clear the sticky error flags.
REQ-010 o_sp  output  16  SHALL be the registered stack pointer.
REQ-011 o_addr  output  16  SHALL be the registered memory address for the accepted operation.
REQ-012 o_valid  output  1  SHALL pulse high for one cycle when o_addr holds the address of an accepted push or pop.
REQ-013 o_we  output  1  SHALL be high with o_valid for a push (memory write), and low for a pop (memory read).
REQ-014 o_depth  output  16  SHALL be the registered count of occupied entries.
REQ-015 o_overflow, o_underflow  output  1 each  SHALL be sticky error flags.

Function
REQ-016 Priority per cycle SHALL be: i_load, then push and pop together, then push alone, then pop alone, then idle.
REQ-017 Load SHALL set o_sp=i_load_val and o_depth=(EMPTY_SP-i_load_val) mod 2^16, and SHALL leave o_valid low.
REQ-018 An accepted push SHALL set o_addr=o_sp-1, o_sp=o_sp-1, o_depth+1, o_we=1 and o_valid=1 (pre-decrement).
REQ-019 An accepted pop SHALL set o_addr=o_sp, o_sp=o_sp+1, o_depth-1, o_we=0 and o_valid=1 (post-increment).
REQ-020 Push and pop together with depth>0 SHALL leave o_sp and o_depth unchanged, set o_addr=o_sp, o_we=1 and o_valid=1 (replace top).
REQ-021 Push and pop together at depth=0 SHALL set o_underflow and change nothing else.
REQ-022 A push with o_sp==LIMIT_SP SHALL be rejected: o_sp unchanged, o_valid=0, o_overflow set.
REQ-023 A pop with o_sp==EMPTY_SP SHALL be rejected: o_sp unchanged, o_valid=0, o_underflow set.
REQ-024 All ±1 arithmetic SHALL be modulo 2^16; a push from 16'h0000 SHALL wrap to 16'hFFFF.
REQ-025 Latency SHALL be one cycle: o_sp, o_addr, o_valid and o_we reflect the request at the next rising edge.
REQ-026 In idle cycles o_valid and o_we SHALL be 0 and o_addr SHALL hold its last value.
REQ-027 i_clr_err SHALL clear both flags on the next edge; if a new error occurs in the same cycle, the flag SHALL remain set.

Reset
REQ-028 While i_rst_n=0, the block SHALL immediately force o_sp=EMPTY_SP, o_addr=EMPTY_SP, o_depth=0 and o_valid=o_we=o_overflow=o_underflow=0.
REQ-029 Reset asserted mid-operation SHALL discard any request in flight, with no o_valid pulse after release.
REQ-030 The first request SHALL be honoured on the first rising edge after i_rst_n deasserts.

Structure
REQ-031 A shared package SHALL hold the 16-bit word width constant and the defaults for EMPTY_SP and LIMIT_SP.
REQ-032 The ±1 arithmetic SHALL be one combinational sub-module, sp_addsub16, instantiated once for o_sp and reused for o_depth through a second instance.

Verification
REQ-033 Reset then 3 pushes -> o_addr FFFF, FFFE, FFFD; o_sp=FFFD; o_depth=3; o_we=1 each cycle.
REQ-034 Continuing from REQ-033, 3 pops -> o_addr FFFD, FFFE, FFFF; o_sp=0000; o_depth=0; then a 4th pop -> o_valid=0, o_underflow=1.
REQ-035 Load F001, push, push -> first push gives o_addr=F000 with o_valid=1; second push gives o_valid=0, o_overflow=1, o_sp=F000.
REQ-036 With o_sp=FFFE, push and pop together -> o_addr=FFFE, o_we=1, o_sp=FFFE; same stimulus at depth 0 -> o_underflow=1.
REQ-037 i_clr_err together with a rejected pop -> o_underflow stays 1; i_clr_err alone on the next cycle -> 0.
REQ-038 Assert i_rst_n low between edges during a push -> outputs reset immediately, with no o_valid pulse after release.
